// File: rtl/secded_stream_decoder_if.sv
// Stream bundle for the SECDED(13,8) decoder: codeword input handshake and
// classified/corrected result output handshake.
interface secded_stream_decoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [12:0] in_codeword;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [12:0] out_codeword;
  logic [3:0]  out_tag;
  logic [3:0]  out_syndrome;
  logic        out_overall_parity;
  logic        no_error;
  logic        one_bit_error;
  logic        parity_error;
  logic        two_bit_error;

  modport master (
    output in_valid, in_codeword, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_codeword, out_tag, out_syndrome,
           out_overall_parity, no_error, one_bit_error, parity_error, two_bit_error
  );

  modport slave (
    input  in_valid, in_codeword, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_codeword, out_tag, out_syndrome,
           out_overall_parity, no_error, one_bit_error, parity_error, two_bit_error
  );
endinterface

// File: rtl/secded_stream_decoder.sv
// Two-stage SECDED(13,8) stream decoder: S1 latches the codeword, syndrome is
// decoded behind it, S2 latches the corrected result. Global stall on backpressure.
module secded_stream_decoder (
  input  logic                   clk,
  input  logic                   rst,
  secded_stream_decoder_if.slave s,
  input  logic                   cnt_clear,
  output logic [7:0]             corr_count,
  output logic [7:0]             uncorr_count
);
  localparam int STAGES = 2;

  logic [STAGES:1] vld_pipe_q;
  logic [12:0]     s1_cw_q;
  logic [3:0]      s1_tag_q;
  logic            adv;

  assign adv        = !vld_pipe_q[STAGES] || s.out_ready;
  assign s.in_ready = adv;
  assign s.out_valid = vld_pipe_q[STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      s1_cw_q    <= '0;
      s1_tag_q   <= '0;
    end else if (adv) begin
      vld_pipe_q <= {vld_pipe_q[1], s.in_valid};
      s1_cw_q    <= s.in_codeword;
      s1_tag_q   <= s.in_tag;
    end
  end

  // Syndrome bit i covers positions whose 1-based index has bit i set.
  logic [3:0]  syn;
  logic        par;
  logic        c_no, c_one, c_par, c_two;
  logic [12:0] flip_mask, cw_fix;
  logic [7:0]  data_fix;

  always_comb begin
    syn = '0;
    for (int j = 0; j < 12; j++) begin
      for (int i = 0; i < 4; i++) begin
        if ((((j + 1) >> i) & 1) != 0) syn[i] = syn[i] ^ s1_cw_q[j];
      end
    end
    par   = ^s1_cw_q;
    c_no  = (syn == 4'd0) && !par;
    c_par = (syn == 4'd0) && par;
    c_one = (syn != 4'd0) && par && (syn <= 4'd12);
    c_two = (syn != 4'd0) && !c_one;
    flip_mask = '0;
    if (c_one)      flip_mask = 13'd1 << (syn - 4'd1);
    else if (c_par) flip_mask = 13'h1000;
    cw_fix   = s1_cw_q ^ flip_mask;
    data_fix = {cw_fix[11:8], cw_fix[6:4], cw_fix[2]};
  end

  logic [7:0]  data_q;
  logic [12:0] cw_q;
  logic [3:0]  tag_q, syn_q;
  logic        par_q;
  logic [3:0]  cls_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      cw_q   <= '0;
      tag_q  <= '0;
      syn_q  <= '0;
      par_q  <= 1'b0;
      cls_q  <= '0;
    end else if (adv) begin
      data_q <= data_fix;
      cw_q   <= cw_fix;
      tag_q  <= s1_tag_q;
      syn_q  <= syn;
      par_q  <= par;
      cls_q  <= vld_pipe_q[1] ? {c_no, c_one, c_par, c_two} : 4'b0000;
    end
  end

  assign s.out_data           = data_q;
  assign s.out_codeword       = cw_q;
  assign s.out_tag            = tag_q;
  assign s.out_syndrome       = syn_q;
  assign s.out_overall_parity = par_q;
  assign s.no_error           = cls_q[3];
  assign s.one_bit_error      = cls_q[2];
  assign s.parity_error       = cls_q[1];
  assign s.two_bit_error      = cls_q[0];

  logic       hs;
  logic [7:0] corr_d, corr_q, uncorr_d, uncorr_q;

  assign hs = vld_pipe_q[STAGES] && s.out_ready;

  always_comb begin
    corr_d   = corr_q;
    uncorr_d = uncorr_q;
    if (cnt_clear) begin
      corr_d   = '0;
      uncorr_d = '0;
    end else if (hs) begin
      if ((cls_q[2] || cls_q[1]) && corr_q != 8'hFF) corr_d = corr_q + 8'd1;
      if (cls_q[0] && uncorr_q != 8'hFF)            uncorr_d = uncorr_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      corr_q   <= '0;
      uncorr_q <= '0;
    end else begin
      corr_q   <= corr_d;
      uncorr_q <= uncorr_d;
    end
  end

  assign corr_count   = corr_q;
  assign uncorr_count = uncorr_q;
endmodule
